// File: rtl/shift_rows_pkg.sv
// Shared AES definitions: state geometry and the (row, col) -> bit offset
// mapping used by every round block that addresses individual state bytes.
package shift_rows_pkg;

  localparam int STATE_W = 128;
  localparam int BYTE_W  = 8;
  localparam int NB      = 4;
  localparam int NBYTES  = STATE_W / BYTE_W;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [BYTE_W-1:0]  byte_t;

  // Transform direction for ShiftRows and its inverse.
  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_INV = 1'b1
  } dir_e;

  // Column-major byte numbering: byte k sits at row k%4, column k/4.
  function automatic int byte_index(input int row, input int col);
    return NB * col + row;
  endfunction

  // Bit offset of the least significant bit of byte (row, col).
  // Byte 0 occupies the most significant 8 bits of the state word.
  function automatic int byte_lsb(input int row, input int col);
    return STATE_W - BYTE_W * (byte_index(row, col) + 1);
  endfunction

  // Source column feeding destination (row, col): forward rotates each
  // row left by its row number, the inverse rotates it right.
  function automatic int src_col(input int row, input int col, input dir_e dir);
    if (dir == DIR_INV) begin
      return (col + NB - row) % NB;
    end
    return (col + row) % NB;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation. Pure wiring plus
// one 2:1 word mux; reusable anywhere in the cipher datapath.
module shift_rows_perm
  import shift_rows_pkg::*;
(
  input  logic [STATE_W-1:0] data_in,
  input  logic               inv,
  output logic [STATE_W-1:0] data_out
);

  logic [STATE_W-1:0] fwd_word;
  logic [STATE_W-1:0] inv_word;

  // Both directions are built as fixed wiring; only the final mux depends on inv.
  genvar gi, gj;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_row
      for (gj = 0; gj < NB; gj++) begin : g_col
        localparam int DST   = byte_lsb(gi, gj);
        localparam int SRC_F = byte_lsb(gi, src_col(gi, gj, DIR_FWD));
        localparam int SRC_I = byte_lsb(gi, src_col(gi, gj, DIR_INV));

        assign fwd_word[DST +: BYTE_W] = data_in[SRC_F +: BYTE_W];
        assign inv_word[DST +: BYTE_W] = data_in[SRC_I +: BYTE_W];
      end
    end
  endgenerate

  // Direction select for the whole word.
  always_comb begin
    data_out = fwd_word;
    if (inv) begin
      data_out = inv_word;
    end
  end

endmodule

// File: rtl/shift_rows.sv
// ShiftRows round block: the combinational permutation followed by a single
// valid/ready output register. One result per cycle when downstream keeps up.
module shift_rows
  import shift_rows_pkg::*;
#(
  parameter int INV_EN = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               inv,
  input  logic [STATE_W-1:0] state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] nstate
);

  logic               inv_sel;
  logic               load;
  logic [STATE_W-1:0] perm_out;

  // Forward-only builds force the direction low so the inverse mux path folds away.
  assign inv_sel = inv & (INV_EN != 0);

  // The register may take new data whenever it is empty or being drained now.
  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready;

  shift_rows_perm u_perm (
    .data_in  (state),
    .inv      (inv_sel),
    .data_out (perm_out)
  );

  // Output stage: reload on accept, drop valid when drained without a refill, else hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      nstate    <= '0;
    end else if (in_ready) begin
      if (load) begin
        out_valid <= 1'b1;
        nstate    <= perm_out;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_rows.sv
// Self-checking bench for shift_rows: array-based reference permutation,
// per-cycle handshake model, directed literals, random traffic and round-trips.
module tb_shift_rows;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid = 1'b0;
  logic         inv = 1'b0;
  logic [127:0] state = '0;
  logic         out_ready = 1'b0;

  logic         in_ready, out_valid;
  logic [127:0] nstate;
  logic         in_ready0, out_valid0;
  logic [127:0] nstate0;

  int checks = 0;
  int errors = 0;

  // Model state
  logic         m_valid = 1'b0;
  logic [127:0] m_nstate = '0;
  logic [127:0] m0_nstate = '0;

  always #5 clk = ~clk;

  shift_rows #(.INV_EN(1)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .inv(inv), .state(state), .out_valid(out_valid), .out_ready(out_ready),
    .nstate(nstate)
  );

  shift_rows #(.INV_EN(0)) dut0 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready0),
    .inv(inv), .state(state), .out_valid(out_valid0), .out_ready(out_ready),
    .nstate(nstate0)
  );

  // Reference: unpack into a 4x4 byte matrix, rotate rows, repack.
  function automatic logic [127:0] shift_model(input logic [127:0] s, input logic dir_inv);
    logic [7:0]   b [4][4];
    logic [127:0] res;
    int           sc;
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[r][c] = s[127 - 8*(4*c + r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        sc = dir_inv ? (c - r + 4) % 4 : (c + r) % 4;
        res[127 - 8*(4*c + r) -: 8] = b[r][sc];
      end
    return res;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Handshake model: one-deep register, loads on accept, empties when drained.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid   <= 1'b0;
      m_nstate  <= '0;
      m0_nstate <= '0;
    end else if (!m_valid || out_ready) begin
      if (in_valid) begin
        m_valid   <= 1'b1;
        m_nstate  <= shift_model(state, inv);
        m0_nstate <= shift_model(state, 1'b0);
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    check("out_valid", {127'd0, out_valid}, {127'd0, m_valid});
    check("nstate", nstate, m_nstate);
    check("in_ready", {127'd0, in_ready}, {127'd0, (!m_valid || out_ready)});
    check("out_valid0", {127'd0, out_valid0}, {127'd0, m_valid});
    check("nstate0", nstate0, m0_nstate);
    check("in_ready0", {127'd0, in_ready0}, {127'd0, (!m_valid || out_ready)});
  end

  localparam logic [127:0] PLAIN = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] SHIFT = 128'h0055AAFF_4499EE33_88DD2277_CC1166BB;

  logic [127:0] vec [5];
  logic [127:0] s, f, held;

  initial begin
    // Pin the model against hand-computed vectors
    check("model_fwd", shift_model(PLAIN, 1'b0), SHIFT);
    check("model_inv", shift_model(SHIFT, 1'b1), PLAIN);
    check("model_fwd_row0", shift_model(128'h01000000_02000000_03000000_04000000, 1'b0),
          128'h01000000_02000000_03000000_04000000);

    // Reset state
    #2;
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_nstate", nstate, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;

    // Forward literal
    @(posedge clk); #1;
    state = PLAIN; inv = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check("lit_fwd", nstate, SHIFT);
    check("lit_fwd_valid", {127'd0, out_valid}, 128'd1);
    // Inverse literal
    state = SHIFT; inv = 1'b1;
    @(posedge clk); #1;
    check("lit_inv", nstate, PLAIN);
    check("lit_inv0_fwd_only", nstate0, shift_model(SHIFT, 1'b0));
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Back-to-back: four consecutive results, in_ready held high
    for (int i = 0; i < 4; i++) vec[i] = rand128();
    out_ready = 1'b1; in_valid = 1'b1; inv = 1'b0; state = vec[0];
    for (int i = 0; i < 4; i++) begin
      check("b2b_in_ready", {127'd0, in_ready}, 128'd1);
      @(posedge clk); #1;
      check("b2b_nstate", nstate, shift_model(vec[i], 1'b0));
      check("b2b_valid", {127'd0, out_valid}, 128'd1);
      if (i < 3) state = vec[i+1];
      else in_valid = 1'b0;
    end
    @(posedge clk); #1;

    // Backpressure: hold for three cycles, then drain and accept next
    vec[0] = rand128(); vec[1] = rand128();
    out_ready = 1'b0; in_valid = 1'b1; inv = 1'b0; state = vec[0];
    @(posedge clk); #1;
    state = vec[1];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_hold", nstate, shift_model(vec[0], 1'b0));
      check("bp_in_ready", {127'd0, in_ready}, 128'd0);
      check("bp_valid", {127'd0, out_valid}, 128'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_next", nstate, shift_model(vec[1], 1'b0));
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Async reset while a result is held
    out_ready = 1'b0; in_valid = 1'b1; state = rand128();
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ar_pre_valid", {127'd0, out_valid}, 128'd1);
    #2 rstn = 1'b0;
    #1;
    check("ar_valid", {127'd0, out_valid}, 128'd0);
    check("ar_nstate", nstate, 128'd0);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    check("ar_in_ready", {127'd0, in_ready}, 128'd1);
    s = rand128(); state = s; in_valid = 1'b1; inv = 1'b1;
    @(posedge clk); #1;
    check("ar_first", nstate, shift_model(s, 1'b1));
    in_valid = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      inv       = $urandom_range(0, 1) != 0;
      state     = rand128();
    end

    // Random round-trip: forward then inverse recovers the original
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      s = rand128();
      state = s; inv = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      f = nstate;
      state = f; inv = 1'b1;
      @(posedge clk); #1;
      check("round_trip", nstate, s);
    end
    in_valid = 1'b0;
    held = nstate;
    @(posedge clk); #1;
    check("drain_valid", {127'd0, out_valid}, 128'd0);
    check("drain_retain", nstate, held);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_rows.md
SHIFT_ROWS -- requirements
Module: shift_rows

Interface
REQ-001 Parameter INV_EN, default 1, meaning: 1 enables inverse ShiftRows via port inv; 0 ties inv off internally and the block performs forward transform only.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  state/inv carry a valid transfer request.
REQ-005 in_ready  output  1  block can accept a transfer this cycle.
REQ-006 inv  input  1  0 = forward ShiftRows, 1 = InvShiftRows; sampled with state.
REQ-007 state  input  128  AES state, byte k = bits [127-8k -: 8], column-major: byte k = row k%4, column k/4.
REQ-008 out_valid  output  1  nstate holds a valid result.
REQ-009 out_ready  input  1  downstream accepts nstate this cycle.
REQ-010 nstate  output  128  registered transformed state, same byte layout as state.

Function
REQ-011 Forward: nstate byte(r,c) = state byte(r,(c+r) mod 4), r,c in 0..3; row 0 unchanged.
REQ-012 Inverse: nstate byte(r,c) = state byte(r,(c-r) mod 4).
REQ-013 Transform is a pure byte permutation; no byte value altered, no arithmetic.
REQ-014 Transfer in occurs on a clock edge with in_valid && in_ready; transfer out occurs with out_valid && out_ready.
REQ-015 in_ready = !out_valid || out_ready (combinational; single output stage, no skid buffer).
REQ-016 Latency 1 cycle: transformed data and out_valid=1 appear the cycle after the input transfer.
REQ-017 Simultaneous output transfer and input transfer in one cycle: register reloads with new result, out_valid stays 1 (full throughput, one result per cycle).
REQ-018 Output transfer without input transfer: out_valid clears to 0 next cycle; nstate retains last value.
REQ-019 While out_valid && !out_ready: nstate and out_valid hold stable; in_ready=0; inputs ignored.
REQ-020 in_valid low: no register update except per REQ-018.
REQ-021 INV_EN=0: inv ignored, forward transform always.

Reset
REQ-022 rstn low asynchronously forces out_valid=0 and nstate=128'h0, regardless of clk.
REQ-023 Reset mid-operation discards any held result; no output transfer is reported for it.
REQ-024 After rstn deasserts, in_ready=1 and the first accepted input produces a result one cycle later.

Structure
REQ-025 Shared AES package holds: state width constant (128), byte width (8), row/column count (4), and the byte-index function (row,col)->bit offset used by all AES round blocks.
REQ-026 One combinational sub-module natural: shift_rows_perm (128-bit in, inv, 128-bit out), reusable by the cipher datapath; shift_rows wraps it with the handshake register.

Verification
REQ-027 Forward: state=00112233_44556677_8899AABB_CCDDEEFF, inv=0 -> next cycle nstate=0055AAFF_4499EE33_88DD2277_CC1166BB, out_valid=1.
REQ-028 Inverse: state=0055AAFF_4499EE33_88DD2277_CC1166BB, inv=1 -> nstate=00112233_44556677_8899AABB_CCDDEEFF.
REQ-029 Back-to-back: in_valid=1 and out_ready=1 for 4 cycles with 4 distinct states -> 4 correct results on consecutive cycles, in_ready constantly 1.
REQ-030 Backpressure: result held with out_ready=0 for 3 cycles -> nstate stable, in_ready=0, new input not accepted; out_ready=1 -> transfer, then next input accepted.
REQ-031 Async reset: assert rstn=0 between clock edges while out_valid=1 -> out_valid=0 and nstate=0 immediately, before next clk edge.
REQ-032 Random round-trip: 1000 random states through forward then inverse -> original state recovered every time; INV_EN=0 build with inv=1 -> forward result.
